// File: rtl/cube_pattern_loader_if.sv
// Host-side bus of cube_pattern_loader: the UART receive line in, the seed word and its status pulses out.
interface cube_pattern_loader_if;
    logic         RxD;
    logic [511:0] Seed;
    logic         SeedLoad;
    logic         FrameErr;
    logic         Busy;

    modport master (output RxD, input Seed, SeedLoad, FrameErr, Busy);
    modport slave  (input RxD, output Seed, SeedLoad, FrameErr, Busy);
endinterface

// File: rtl/cube_pattern_loader.sv
// Receives a sync-byte-framed 64-byte seed for the 8x8x8 cube over 8N1 UART and
// publishes it as one 512-bit word with a single-cycle load strobe.
module cube_pattern_loader #(
    parameter int unsigned CLK_HZ         = 100_000_000,
    parameter int unsigned BAUD           = 115200,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
    input  logic                  Clk,
    input  logic                  Reset,
    cube_pattern_loader_if.slave  bus
);

    localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned HALF_M1      = (CLKS_PER_BIT / 2 > 0) ? CLKS_PER_BIT / 2 - 1 : 0;
    localparam int unsigned TMO_W        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned SEED_W       = 512;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic       {F_HUNT, F_DATA} f_state_t;

    // Two-flop synchroniser plus one delay flop for falling-edge detection
    logic rx_meta, rx_sync, rx_prev;
    logic start_edge_c;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= bus.RxD;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign start_edge_c = rx_prev & ~rx_sync;

    rx_state_t          rx_state_q, rx_state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [7:0]         shreg_q, shreg_d;
    logic               byte_valid_q, byte_valid_d;
    logic               stop_err_q, stop_err_d;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rx_state_q   <= RX_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shreg_q      <= '0;
            byte_valid_q <= 1'b0;
            stop_err_q   <= 1'b0;
        end else begin
            rx_state_q   <= rx_state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shreg_q      <= shreg_d;
            byte_valid_q <= byte_valid_d;
            stop_err_q   <= stop_err_d;
        end
    end

    // Bit-level receiver: mid-bit sampling, glitch rejection on the start bit
    always_comb begin
        rx_state_d   = rx_state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        shreg_d      = shreg_q;
        byte_valid_d = 1'b0;
        stop_err_d   = 1'b0;
        unique case (rx_state_q)
            RX_IDLE: begin
                if (start_edge_c) begin
                    rx_state_d = RX_START;
                    cnt_d      = '0;
                end
            end
            RX_START: begin
                if (cnt_q == CNT_W'(HALF_M1)) begin
                    cnt_d      = '0;
                    bit_idx_d  = '0;
                    rx_state_d = rx_sync ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                    cnt_d     = '0;
                    shreg_d   = {rx_sync, shreg_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                    cnt_d        = '0;
                    byte_valid_d = rx_sync;
                    stop_err_d   = ~rx_sync;
                    rx_state_d   = RX_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    f_state_t            f_state_q, f_state_d;
    logic [5:0]          byte_cnt_q, byte_cnt_d;
    logic [SEED_W-1:0]   shadow_q, shadow_d;
    logic [SEED_W-1:0]   seed_q, seed_d;
    logic                seed_load_q, seed_load_d;
    logic                frame_err_q, frame_err_d;
    logic                busy_q, busy_d;
    logic [TMO_W-1:0]    tcnt_q, tcnt_d;
    logic                line_quiet_c;
    logic                timeout_c;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            f_state_q   <= F_HUNT;
            byte_cnt_q  <= '0;
            shadow_q    <= '0;
            seed_q      <= '0;
            seed_load_q <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
            tcnt_q      <= '0;
        end else begin
            f_state_q   <= f_state_d;
            byte_cnt_q  <= byte_cnt_d;
            shadow_q    <= shadow_d;
            seed_q      <= seed_d;
            seed_load_q <= seed_load_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
            tcnt_q      <= tcnt_d;
        end
    end

    // Inter-byte gap: receiver idle and no new start bit this cycle
    assign line_quiet_c = (rx_state_q == RX_IDLE) && !start_edge_c;
    assign timeout_c    = line_quiet_c && (tcnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

    // Frame assembly; a valid byte always wins over an abort in the same cycle
    always_comb begin
        f_state_d   = f_state_q;
        byte_cnt_d  = byte_cnt_q;
        shadow_d    = shadow_q;
        seed_d      = seed_q;
        seed_load_d = 1'b0;
        frame_err_d = 1'b0;
        tcnt_d      = '0;
        unique case (f_state_q)
            F_HUNT: begin
                if (byte_valid_q && (shreg_q == SYNC_BYTE)) begin
                    f_state_d  = F_DATA;
                    byte_cnt_d = '0;
                    shadow_d   = '0;
                end
            end
            F_DATA: begin
                if (byte_valid_q) begin
                    if (byte_cnt_q == 6'd63) begin
                        seed_d      = {shreg_q, shadow_q[SEED_W-9:0]};
                        seed_load_d = 1'b1;
                        shadow_d    = '0;
                        f_state_d   = F_HUNT;
                    end else begin
                        shadow_d[{byte_cnt_q, 3'b000} +: 8] = shreg_q;
                        byte_cnt_d = byte_cnt_q + 6'd1;
                    end
                end else if (stop_err_q || timeout_c) begin
                    frame_err_d = 1'b1;
                    shadow_d    = '0;
                    f_state_d   = F_HUNT;
                end else if (line_quiet_c) begin
                    tcnt_d = tcnt_q + TMO_W'(1);
                end
            end
            default: f_state_d = F_HUNT;
        endcase
        busy_d = (f_state_d == F_DATA);
    end

    assign bus.Seed     = seed_q;
    assign bus.SeedLoad = seed_load_q;
    assign bus.FrameErr = frame_err_q;
    assign bus.Busy     = busy_q;

endmodule

// File: tb/tb_cube_pattern_loader.sv
// Bench for cube_pattern_loader: UART byte driver, seed scoreboard, pulse counters.
module tb_cube_pattern_loader;

    localparam int unsigned CPB = 10;
    localparam int unsigned GAP = 10;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    cube_pattern_loader_if bus ();

    cube_pattern_loader #(
        .CLK_HZ         (1_000_000),
        .BAUD           (100_000),
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (500)
    ) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int load_cnt = 0;
    int err_cnt  = 0;
    logic [511:0] exp_q[$];
    logic [511:0] last_seed;

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Every SeedLoad must match the oldest queued frame
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.SeedLoad) begin
                load_cnt++;
                check_eq("load_expected", 512'(exp_q.size() != 0), 512'(1));
                if (exp_q.size() != 0) begin
                    check_eq("seed_on_load", bus.Seed, exp_q.pop_front());
                end
            end
            if (bus.FrameErr) begin
                err_cnt++;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
        bus.RxD = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.RxD = b[i];
            repeat (CPB) @(negedge clk);
        end
        bus.RxD = stop_bit;
        repeat (CPB) @(negedge clk);
        bus.RxD = 1'b1;
        repeat (GAP) @(negedge clk);
    endtask

    task automatic send_frame(input logic [511:0] pat);
        exp_q.push_back(pat);
        last_seed = pat;
        send_byte(8'hA5);
        for (int k = 0; k < 64; k++) begin
            send_byte(pat[8*k +: 8]);
        end
    endtask

    function automatic logic [511:0] rand_pat();
        logic [511:0] p;
        for (int k = 0; k < 16; k++) begin
            p[32*k +: 32] = $urandom;
        end
        return p;
    endfunction

    initial begin
        int l0;
        int e0;
        logic [511:0] pat;

        rst     = 1'b1;
        bus.RxD = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("reset_seed", bus.Seed, '0);
        check_eq("reset_flags", 512'({bus.SeedLoad, bus.FrameErr, bus.Busy}), '0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Ascending-byte frame
        l0 = load_cnt; e0 = err_cnt;
        for (int k = 0; k < 64; k++) pat[8*k +: 8] = 8'(k);
        send_frame(pat);
        repeat (20) @(negedge clk);
        check_eq("t1_loads", 512'(load_cnt - l0), 512'(1));
        check_eq("t1_errs", 512'(err_cnt - e0), '0);
        check_eq("t1_low_byte", 512'(bus.Seed[7:0]), 512'(8'h00));
        check_eq("t1_high_byte", 512'(bus.Seed[511:504]), 512'(8'h3F));
        check_eq("t1_busy", 512'(bus.Busy), '0);

        // Junk before header is dropped
        l0 = load_cnt; e0 = err_cnt;
        send_byte(8'h11);
        send_byte(8'h22);
        send_frame('1);
        repeat (20) @(negedge clk);
        check_eq("t2_loads", 512'(load_cnt - l0), 512'(1));
        check_eq("t2_errs", 512'(err_cnt - e0), '0);
        check_eq("t2_seed", bus.Seed, '1);

        // Bad stop bit mid-frame, then recovery
        l0 = load_cnt; e0 = err_cnt;
        send_byte(8'hA5);
        for (int k = 0; k < 10; k++) send_byte(8'($urandom));
        check_eq("t3_busy_mid", 512'(bus.Busy), 512'(1));
        send_byte(8'h5A, 1'b0);
        repeat (20) @(negedge clk);
        check_eq("t3_errs", 512'(err_cnt - e0), 512'(1));
        check_eq("t3_no_load", 512'(load_cnt - l0), '0);
        check_eq("t3_seed_kept", bus.Seed, last_seed);
        check_eq("t3_busy", 512'(bus.Busy), '0);
        l0 = load_cnt;
        send_frame(rand_pat());
        repeat (20) @(negedge clk);
        check_eq("t3_reload", 512'(load_cnt - l0), 512'(1));

        // Inter-byte timeout
        l0 = load_cnt; e0 = err_cnt;
        send_byte(8'hA5);
        for (int k = 0; k < 5; k++) send_byte(8'($urandom));
        repeat (400) @(negedge clk);
        check_eq("t4_no_early_err", 512'(err_cnt - e0), '0);
        check_eq("t4_busy_wait", 512'(bus.Busy), 512'(1));
        repeat (200) @(negedge clk);
        check_eq("t4_timeout_err", 512'(err_cnt - e0), 512'(1));
        check_eq("t4_seed_kept", bus.Seed, last_seed);
        check_eq("t4_busy", 512'(bus.Busy), '0);
        check_eq("t4_no_load", 512'(load_cnt - l0), '0);

        // Short glitch on idle line
        l0 = load_cnt; e0 = err_cnt;
        bus.RxD = 1'b0;
        repeat (4) @(negedge clk);
        bus.RxD = 1'b1;
        repeat (50) @(negedge clk);
        check_eq("t5_glitch_pulses", 512'((load_cnt - l0) + (err_cnt - e0)), '0);
        check_eq("t5_glitch_busy", 512'(bus.Busy), '0);

        // Asynchronous reset mid-frame
        send_byte(8'hA5);
        for (int k = 0; k < 3; k++) send_byte(8'($urandom));
        check_eq("t5_busy_before_rst", 512'(bus.Busy), 512'(1));
        bus.RxD = 1'b0;
        repeat (15) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("t5_rst_seed", bus.Seed, '0);
        check_eq("t5_rst_flags", 512'({bus.SeedLoad, bus.FrameErr, bus.Busy}), '0);
        bus.RxD = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        l0 = load_cnt;
        send_frame(rand_pat());
        repeat (20) @(negedge clk);
        check_eq("t5_reload", 512'(load_cnt - l0), 512'(1));

        // Sync byte inside payload is plain data
        l0 = load_cnt; e0 = err_cnt;
        pat = rand_pat();
        pat[63:56] = 8'hA5;
        send_frame(pat);
        repeat (20) @(negedge clk);
        check_eq("t6_loads", 512'(load_cnt - l0), 512'(1));
        check_eq("t6_errs", 512'(err_cnt - e0), '0);
        check_eq("t6_byte7", 512'(bus.Seed[63:56]), 512'(8'hA5));

        check_eq("queue_drained", 512'(exp_q.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
